// File: rtl/wb_pipe_slice_pkg.sv
// wb_pipe_slice_pkg: channel indices and default widths shared by the write-back slice.
package wb_pipe_slice_pkg;
  localparam int CH_GPR     = 0;
  localparam int CH_HILO    = 1;
  localparam int CH_LLBIT   = 2;
  localparam int CH_CP0     = 3;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_PC_W   = 32;
endpackage

// File: rtl/wb_slice_entry.sv
// wb_slice_entry: one held pipeline entry (valid, write enables, payloads, pc).
module wb_slice_entry
  import wb_pipe_slice_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int PC_W   = DEF_PC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     load,
  input  logic [NUM_CH-1:0]        d_we,
  input  logic [NUM_CH*DATA_W-1:0] d_data,
  input  logic [PC_W-1:0]          d_pc,
  output logic                     valid,
  output logic [NUM_CH-1:0]        we,
  output logic [NUM_CH*DATA_W-1:0] data,
  output logic [PC_W-1:0]          pc
);
  // clear zeroes the payload so an empty entry drives a clean bubble; pc stays sticky
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      we    <= '0;
      data  <= '0;
      pc    <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      we    <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      we    <= d_we;
      data  <= d_data;
      pc    <= d_pc;
    end
  end
endmodule

// File: rtl/wb_pipe_slice.sv
// wb_pipe_slice: memory-to-write-back pipeline register with valid/ready, optional skid entry and stall counter.
module wb_pipe_slice
  import wb_pipe_slice_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int PC_W   = DEF_PC_W,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH-1:0]        in_we,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        out_we,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [PC_W-1:0]          out_pc,
  output logic [CNT_W-1:0]         stall_cnt
);
  logic                     s_valid;
  logic [NUM_CH-1:0]        s_we;
  logic [NUM_CH*DATA_W-1:0] s_data;
  logic [PC_W-1:0]          s_pc;
  logic acc, ret, m_load_s, m_load_in, s_load, m_clr, s_clr;
  always_comb begin
    in_ready  = SKID ? !s_valid : (!out_valid || out_ready);
    acc       = in_valid && in_ready;
    ret       = out_valid && out_ready;
    m_load_s  = ret && s_valid;
    m_load_in = acc && (!out_valid || ret);
    s_load    = acc && out_valid && !ret;
    m_clr     = flush || (ret && !m_load_s && !m_load_in);
    s_clr     = flush || m_load_s;
  end
  wb_slice_entry #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .PC_W(PC_W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .clr   (m_clr),
    .load  (m_load_s || m_load_in),
    .d_we  (m_load_s ? s_we : in_we),
    .d_data(m_load_s ? s_data : in_data),
    .d_pc  (m_load_s ? s_pc : in_pc),
    .valid (out_valid),
    .we    (out_we),
    .data  (out_data),
    .pc    (out_pc)
  );
  if (SKID) begin : g_skid
    wb_slice_entry #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .PC_W(PC_W)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .clr   (s_clr),
      .load  (s_load),
      .d_we  (in_we),
      .d_data(in_data),
      .d_pc  (in_pc),
      .valid (s_valid),
      .we    (s_we),
      .data  (s_data),
      .pc    (s_pc)
    );
  end else begin : g_noskid
    assign s_valid = 1'b0;
    assign s_we    = '0;
    assign s_data  = '0;
    assign s_pc    = '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_wb_pipe_slice.sv
// tb_wb_pipe_slice: directed scoreboard bench for the skid and single-entry slice variants.
module tb_wb_pipe_slice;
  import wb_pipe_slice_pkg::*;
  localparam int DW = 32, NC = 4, PW = 32;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, out_ready0 = 1'b1;
  logic [NC-1:0] in_we = '0;
  logic [NC*DW-1:0] in_data = '0;
  logic [PW-1:0] in_pc = '0;
  logic in_ready, out_valid, in_ready0, out_valid0;
  logic [NC-1:0] out_we, out_we0;
  logic [NC*DW-1:0] out_data, out_data0;
  logic [PW-1:0] out_pc, out_pc0;
  logic [15:0] stall_cnt;
  logic [3:0] stall_cnt0;
  typedef struct {logic [NC-1:0] we; logic [NC*DW-1:0] data; logic [PW-1:0] pc;} ent_t;
  ent_t q[$];
  int checks = 0, failures = 0;
  bit acc_f;

  wb_pipe_slice #(.DATA_W(DW), .NUM_CH(NC), .PC_W(PW), .SKID(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_we(in_we), .in_data(in_data), .in_pc(in_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_we(out_we), .out_data(out_data), .out_pc(out_pc),
    .stall_cnt(stall_cnt));

  wb_pipe_slice #(.DATA_W(DW), .NUM_CH(NC), .PC_W(PW), .SKID(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_we(in_we), .in_data(in_data), .in_pc(in_pc), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_we(out_we0), .out_data(out_data0), .out_pc(out_pc0),
    .stall_cnt(stall_cnt0));

  always #5 clk = ~clk;

  function automatic logic [NC-1:0] we_of(int i);
    return NC'(i + 1);
  endfunction
  function automatic logic [NC*DW-1:0] data_of(int i);
    return {32'(i) + 32'h3000_0000, 32'(i) + 32'h2000_0000, 32'(i) + 32'h1000_0000, 32'(i) + 32'h0C00_0000};
  endfunction
  function automatic logic [PW-1:0] pc_of(int i);
    return 32'hA000_0000 + 32'(i * 4);
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(int i);
    in_valid = 1'b1;
    in_we    = we_of(i);
    in_data  = data_of(i);
    in_pc    = pc_of(i);
  endtask

  // sample at the falling edge, then advance to just after the rising edge
  task automatic cycle();
    ent_t e;
    @(negedge clk);
    acc_f = 1'b0;
    if (rst) begin
      if (!out_valid) begin
        chk("bubble_we", 128'(out_we), 128'(0));
        chk("bubble_data", 128'(out_data), 128'(0));
      end
      if (flush) q.delete();
      else begin
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk("sb_underflow", 128'(q.size()), 128'(1));
          else begin
            e = q.pop_front();
            chk("sb_we", 128'(out_we), 128'(e.we));
            chk("sb_data", 128'(out_data), 128'(e.data));
            chk("sb_pc", 128'(out_pc), 128'(e.pc));
          end
        end
        if (in_valid && in_ready) begin
          q.push_back('{in_we, in_data, in_pc});
          acc_f = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_pc", 128'(out_pc), 128'(0));
    chk("rst_stall", 128'(stall_cnt), 128'(0));
    chk("rst_in_ready0", 128'(in_ready0), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("release_in_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_we = '0;
    in_we[CH_GPR] = 1'b1;
    in_data = {96'h0, 32'h1234_5678};
    in_pc = 32'hBFC0_0000;
    cycle();
    in_valid = 1'b0;
    chk("t1_valid", 128'(out_valid), 128'(1));
    chk("t1_we", 128'(out_we), 128'(4'b0001));
    chk("t1_data", 128'(out_data), 128'h1234_5678);
    chk("t1_pc", 128'(out_pc), 128'(32'hBFC0_0000));
    chk("t1_stall", 128'(stall_cnt), 128'(0));
    for (int i = 0; i < 8; i++) begin
      set_in(i);
      cycle();
      chk("stream_valid", 128'(out_valid), 128'(1));
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_end", 128'(out_valid), 128'(0));
    chk("stream_sb_empty", 128'(q.size()), 128'(0));
    out_ready = 1'b0;
    set_in(8);
    cycle();
    set_in(9);
    cycle();
    chk("skid_ready_low", 128'(in_ready), 128'(0));
    set_in(10);
    cycle();
    cycle();
    chk("skid_stall3", 128'(stall_cnt), 128'(3));
    chk("skid_ready_held", 128'(in_ready), 128'(0));
    chk("skid_head_data", 128'(out_data), 128'(data_of(8)));
    out_ready = 1'b1;
    cycle();
    chk("drain_ready", 128'(in_ready), 128'(1));
    chk("drain_pc", 128'(out_pc), 128'(pc_of(9)));
    cycle();
    in_valid = 1'b0;
    chk("drain_next_pc", 128'(out_pc), 128'(pc_of(10)));
    cycle();
    chk("drain_done", 128'(out_valid), 128'(0));
    chk("drain_sb_empty", 128'(q.size()), 128'(0));
    out_ready = 1'b0;
    set_in(11);
    cycle();
    set_in(12);
    cycle();
    chk("pre_flush_pc", 128'(out_pc), 128'(pc_of(11)));
    flush = 1'b1;
    set_in(13);
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_we", 128'(out_we), 128'(0));
    chk("flush_data", 128'(out_data), 128'(0));
    chk("flush_pc_kept", 128'(out_pc), 128'(pc_of(11)));
    chk("flush_stall_kept", 128'(stall_cnt), 128'(5));
    chk("flush_ready", 128'(in_ready), 128'(1));
    chk("flush_valid0", 128'(out_valid0), 128'(0));
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("flush_no_ghost", 128'(out_valid), 128'(0));
    out_ready0 = 1'b0;
    set_in(14);
    cycle();
    in_valid = 1'b0;
    chk("sat_valid0", 128'(out_valid0), 128'(1));
    chk("sat_ready0_low", 128'(in_ready0), 128'(0));
    repeat (14) cycle();
    chk("sat_cnt14", 128'(stall_cnt0), 128'(14));
    repeat (6) cycle();
    chk("sat_cnt15", 128'(stall_cnt0), 128'(15));
    out_ready0 = 1'b1;
    #1;
    chk("comb_ready0", 128'(in_ready0), 128'(1));
    cycle();
    chk("sat_drained0", 128'(out_valid0), 128'(0));
    out_ready = 1'b0;
    set_in(15);
    cycle();
    set_in(16);
    cycle();
    chk("pre_rst_valid", 128'(out_valid), 128'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("async_valid", 128'(out_valid), 128'(0));
    chk("async_we", 128'(out_we), 128'(0));
    chk("async_data", 128'(out_data), 128'(0));
    chk("async_pc", 128'(out_pc), 128'(0));
    chk("async_stall", 128'(stall_cnt), 128'(0));
    chk("async_ready", 128'(in_ready), 128'(1));
    q.delete();
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    cycle();
    chk("post_rst_ready", 128'(in_ready), 128'(1));
    set_in(17);
    cycle();
    in_valid = 1'b0;
    chk("post_rst_valid", 128'(out_valid), 128'(1));
    chk("post_rst_pc", 128'(out_pc), 128'(pc_of(17)));
    cycle();
    chk("final_sb_empty", 128'(q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
